data_memory: RTL and testbench

Parametrised RISC-V data memory with a valid/ready request/response handshake and configurable access latency. Supports byte, halfword and word stores through byte-lane enables, and sign- or zero-extending loads. Detects misaligned accesses and illegal size codes, and reports them on the response instead of committing them. Sits between the core's load/store stage and on-chip storage, and replaces the fixed single-cycle word-only RAM.

---
 rtl/dmem_pkg.sv | 16 +
 rtl/dmem_lane_align.sv | 59 +++++
 rtl/data_memory.sv | 143 ++++++++++++++
 tb/tb_data_memory.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared constants and types for the data memory: RISC-V funct3 size codes and FSM states.
package dmem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering for the data memory: store enables/data, load extract/extend,
// and misaligned/illegal access detection from funct3, addr[1:0] and direction.
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  addr_lo_i,
    input  logic        write_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rword_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    output logic [31:0] rdata_o,
    output logic        misalign_o,
    output logic        illegal_o
);

    logic [31:0] rsh;

    always_comb begin
        be_o       = 4'b0000;
        wdata_o    = 32'h0;
        rdata_o    = 32'h0;
        misalign_o = 1'b0;
        illegal_o  = 1'b0;
        // Selected byte/halfword lands in the low bits for extraction.
        rsh        = rword_i >> {addr_lo_i, 3'b000};
        case (funct3_i)
            F3_B: begin
                be_o    = 4'b0001 << addr_lo_i;
                wdata_o = {4{wdata_i[7:0]}};
                rdata_o = {{24{rsh[7]}}, rsh[7:0]};
            end
            F3_H: begin
                misalign_o = addr_lo_i[0];
                be_o       = addr_lo_i[1] ? 4'b1100 : 4'b0011;
                wdata_o    = {2{wdata_i[15:0]}};
                rdata_o    = {{16{rsh[15]}}, rsh[15:0]};
            end
            F3_W: begin
                misalign_o = |addr_lo_i;
                be_o       = 4'b1111;
                wdata_o    = wdata_i;
                rdata_o    = rword_i;
            end
            F3_BU: begin
                illegal_o = write_i;
                rdata_o   = {24'h0, rsh[7:0]};
            end
            F3_HU: begin
                illegal_o  = write_i;
                misalign_o = addr_lo_i[0];
                rdata_o    = {16'h0, rsh[15:0]};
            end
            default: illegal_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/data_memory.sv
// RISC-V data memory with valid/ready request/response and WAIT_STATES access latency.
// Define DMEM_BOUNDS_CHECK_EN to reject addresses beyond DEPTH words instead of aliasing.
module data_memory
    import dmem_pkg::*;
#(
    parameter int DEPTH       = 64,
    parameter int WAIT_STATES = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int         AW = $clog2(DEPTH);
    localparam logic [3:0] WS = 4'(WAIT_STATES);
`ifdef DMEM_BOUNDS_CHECK_EN
    localparam bit BOUNDS_EN = 1'b1;
`else
    localparam bit BOUNDS_EN = 1'b0;
`endif

    state_e      state_q;
    logic [3:0]  cnt_q;
    logic        write_q;
    logic [2:0]  funct3_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] rdata_q;
    logic        err_q;
    logic [31:0] mem_q [DEPTH];

    logic        acc_write;
    logic [2:0]  acc_funct3;
    logic [31:0] acc_addr;
    logic [31:0] acc_wdata;
    logic [AW-1:0] acc_idx;
    logic [3:0]  be;
    logic [31:0] wdata_sh;
    logic [31:0] rdata_ext;
    logic        misalign;
    logic        illegal;
    logic        oob;
    logic        err_d;
    logic [31:0] rdata_d;
    logic        accept;
    logic        do_access;

    // With zero wait states the access happens on the accept edge, so it must
    // see the live request rather than the not-yet-latched copy.
    assign acc_write  = (state_q == IDLE) ? req_write  : write_q;
    assign acc_funct3 = (state_q == IDLE) ? req_funct3 : funct3_q;
    assign acc_addr   = (state_q == IDLE) ? req_addr   : addr_q;
    assign acc_wdata  = (state_q == IDLE) ? req_wdata  : wdata_q;
    assign acc_idx    = acc_addr[2 +: AW];

    dmem_lane_align u_align (
        .funct3_i   (acc_funct3),
        .addr_lo_i  (acc_addr[1:0]),
        .write_i    (acc_write),
        .wdata_i    (acc_wdata),
        .rword_i    (mem_q[acc_idx]),
        .be_o       (be),
        .wdata_o    (wdata_sh),
        .rdata_o    (rdata_ext),
        .misalign_o (misalign),
        .illegal_o  (illegal)
    );

    assign oob       = BOUNDS_EN && (acc_addr[31:2+AW] != '0);
    assign err_d     = misalign | illegal | oob;
    assign rdata_d   = (acc_write | err_d) ? 32'h0 : rdata_ext;
    assign accept    = (state_q == IDLE) && req_valid;
    assign do_access = !reset && ((accept && (WS == 4'd0)) ||
                                  ((state_q == WAIT) && (cnt_q == 4'd1)));

    assign req_ready  = (state_q == IDLE);
    assign resp_valid = (state_q == RESP);
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= 4'd0;
            write_q  <= 1'b0;
            funct3_q <= 3'b000;
            addr_q   <= 32'h0;
            wdata_q  <= 32'h0;
            rdata_q  <= 32'h0;
            err_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        write_q  <= req_write;
                        funct3_q <= req_funct3;
                        addr_q   <= req_addr;
                        wdata_q  <= req_wdata;
                        cnt_q    <= WS;
                        state_q  <= (WS == 4'd0) ? RESP : WAIT;
                    end
                end
                WAIT: begin
                    cnt_q <= cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        state_q <= RESP;
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
            if (do_access) begin
                rdata_q <= rdata_d;
                err_q   <= err_d;
            end
        end
    end

    // Storage is deliberately not reset; only enabled lanes of error-free stores land.
    always_ff @(posedge clk) begin
        if (do_access && acc_write && !err_d) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem_q[acc_idx][8*i +: 8] <= wdata_sh[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_data_memory.sv
// Directed bench for data_memory: instance 0 with WAIT_STATES=0, instance 1 with WAIT_STATES=3.
module tb_data_memory;
    import dmem_pkg::*;

    logic        clk;
    logic        reset      [2];
    logic        req_valid  [2];
    logic        req_ready  [2];
    logic        req_write  [2];
    logic [2:0]  req_funct3 [2];
    logic [31:0] req_addr   [2];
    logic [31:0] req_wdata  [2];
    logic        resp_valid [2];
    logic        resp_ready [2];
    logic [31:0] resp_rdata [2];
    logic        resp_err   [2];

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;
    logic [31:0] exp_q[$];
    logic        exp_err_q[$];

    data_memory #(.DEPTH(64), .WAIT_STATES(0)) dut0 (
        .clk(clk), .reset(reset[0]),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_write(req_write[0]),
        .req_funct3(req_funct3[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
        .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]),
        .resp_rdata(resp_rdata[0]), .resp_err(resp_err[0])
    );

    data_memory #(.DEPTH(64), .WAIT_STATES(3)) dut3 (
        .clk(clk), .reset(reset[1]),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_write(req_write[1]),
        .req_funct3(req_funct3[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
        .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]),
        .resp_rdata(resp_rdata[1]), .resp_err(resp_err[1])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Presents a request and returns #1 after the accept edge.
    task automatic issue(input int d, input logic wr, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] exp_rdata, input logic exp_err);
        req_valid[d]  = 1'b1;
        req_write[d]  = wr;
        req_funct3[d] = f3;
        req_addr[d]   = addr;
        req_wdata[d]  = wdata;
        exp_q.push_back(exp_rdata);
        exp_err_q.push_back(exp_err);
        check("req_ready_before_accept", 32'(req_ready[d]), 32'd1);
        @(posedge clk);
        #1;
        req_valid[d] = 1'b0;
    endtask

    task automatic wait_resp(input int d, input int exp_lat);
        int lat = 1;
        logic [31:0] e;
        logic        ee;
        while (!resp_valid[d] && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("resp_latency", 32'(lat), 32'(exp_lat));
        check("req_ready_in_resp", 32'(req_ready[d]), 32'd0);
        e  = exp_q.pop_front();
        ee = exp_err_q.pop_front();
        check("resp_rdata", resp_rdata[d], e);
        check("resp_err", 32'(resp_err[d]), 32'(ee));
    endtask

    task automatic do_req(input int d, input logic wr, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] exp_rdata, input logic exp_err);
        issue(d, wr, f3, addr, wdata, exp_rdata, exp_err);
        wait_resp(d, (d == 0) ? 1 : 4);
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            reset[d]      = 1'b1;
            req_valid[d]  = 1'b0;
            req_write[d]  = 1'b0;
            req_funct3[d] = 3'b000;
            req_addr[d]   = 32'h0;
            req_wdata[d]  = 32'h0;
            resp_ready[d] = 1'b1;
        end
        repeat (3) @(posedge clk);
        #1;
        reset[0] = 1'b0;
        reset[1] = 1'b0;

        for (int d = 0; d < 2; d++) begin
            check("rst_req_ready", 32'(req_ready[d]), 32'd1);
            check("rst_resp_valid", 32'(resp_valid[d]), 32'd0);
            check("rst_resp_rdata", resp_rdata[d], 32'h0);
            check("rst_resp_err", 32'(resp_err[d]), 32'd0);
        end

        // Word store/load, zero wait states
        do_req(0, 1'b1, F3_W, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0);
        do_req(0, 1'b0, F3_W, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0);

        // Byte lanes and extension
        do_req(0, 1'b1, F3_W,  32'h20, 32'h00000000, 32'h0, 1'b0);
        do_req(0, 1'b1, F3_B,  32'h23, 32'h00000080, 32'h0, 1'b0);
        do_req(0, 1'b0, F3_B,  32'h23, 32'h0, 32'hFFFFFF80, 1'b0);
        do_req(0, 1'b0, F3_BU, 32'h23, 32'h0, 32'h00000080, 1'b0);
        do_req(0, 1'b0, F3_W,  32'h20, 32'h0, 32'h80000000, 1'b0);

        // Halfword lanes, extension and misalignment
        do_req(0, 1'b1, F3_W,  32'h0, 32'hAAAAAAAA, 32'h0, 1'b0);
        do_req(0, 1'b1, F3_H,  32'h2, 32'h00001234, 32'h0, 1'b0);
        do_req(0, 1'b0, F3_W,  32'h0, 32'h0, 32'h1234AAAA, 1'b0);
        do_req(0, 1'b0, F3_H,  32'h1, 32'h0, 32'h0, 1'b1);
        do_req(0, 1'b0, F3_W,  32'h0, 32'h0, 32'h1234AAAA, 1'b0);
        do_req(0, 1'b0, F3_H,  32'h2, 32'h0, 32'h00001234, 1'b0);
        do_req(0, 1'b1, F3_H,  32'h0, 32'h00008001, 32'h0, 1'b0);
        do_req(0, 1'b0, F3_H,  32'h0, 32'h0, 32'hFFFF8001, 1'b0);
        do_req(0, 1'b0, F3_HU, 32'h0, 32'h0, 32'h00008001, 1'b0);

        // Rejected accesses leave memory untouched
        do_req(0, 1'b1, F3_W,  32'h22, 32'h55555555, 32'h0, 1'b1);
        do_req(0, 1'b1, F3_BU, 32'h20, 32'h55555555, 32'h0, 1'b1);
        do_req(0, 1'b1, 3'b011, 32'h20, 32'h55555555, 32'h0, 1'b1);
        do_req(0, 1'b0, 3'b011, 32'h20, 32'h0, 32'h0, 1'b1);
        do_req(0, 1'b0, 3'b111, 32'h20, 32'h0, 32'h0, 1'b1);
        do_req(0, 1'b0, F3_W,  32'h20, 32'h0, 32'h80000000, 1'b0);

        // Out-of-range address: rejected or aliased to word 0
`ifdef DMEM_BOUNDS_CHECK_EN
        do_req(0, 1'b1, F3_W, 32'h100, 32'h11111111, 32'h0, 1'b1);
        do_req(0, 1'b0, F3_W, 32'h0, 32'h0, 32'h12348001, 1'b0);
`else
        do_req(0, 1'b1, F3_W, 32'h100, 32'h11111111, 32'h0, 1'b0);
        do_req(0, 1'b0, F3_W, 32'h0, 32'h0, 32'h11111111, 1'b0);
`endif

        // Three wait states: latency 4
        do_req(1, 1'b1, F3_W, 32'h8, 32'h12345678, 32'h0, 1'b0);
        do_req(1, 1'b0, F3_W, 32'h8, 32'h0, 32'h12345678, 1'b0);

        // Reset while in WAIT discards the store
        req_valid[1]  = 1'b1;
        req_write[1]  = 1'b1;
        req_funct3[1] = F3_W;
        req_addr[1]   = 32'h8;
        req_wdata[1]  = 32'h00000055;
        @(posedge clk);
        #1;
        req_valid[1] = 1'b0;
        reset[1]     = 1'b1;
        @(posedge clk);
        #1;
        reset[1] = 1'b0;
        check("wait_rst_req_ready", 32'(req_ready[1]), 32'd1);
        check("wait_rst_resp_valid", 32'(resp_valid[1]), 32'd0);
        repeat (5) @(posedge clk);
        #1;
        check("wait_rst_no_resp", 32'(resp_valid[1]), 32'd0);
        do_req(1, 1'b0, F3_W, 32'h8, 32'h0, 32'h12345678, 1'b0);

        // Back-pressure: response holds while resp_ready is low
        resp_ready[1] = 1'b0;
        issue(1, 1'b0, F3_B, 32'hB, 32'h0, 32'h00000012, 1'b0);
        wait_resp(1, 4);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("hold_resp_valid", 32'(resp_valid[1]), 32'd1);
            check("hold_req_ready", 32'(req_ready[1]), 32'd0);
            check("hold_rdata", resp_rdata[1], 32'h00000012);
        end
        resp_ready[1] = 1'b1;
        @(posedge clk);
        #1;
        check("after_hs_req_ready", 32'(req_ready[1]), 32'd1);
        check("after_hs_resp_valid", 32'(resp_valid[1]), 32'd0);
        do_req(1, 1'b0, F3_HU, 32'hA, 32'h0, 32'h00001234, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
